// File: rtl/alu_sequencer.sv
// Command sequencer for the 8-bit accumulator ALU.
// Commands {opcode, operand} are queued in a small FIFO. Each one is issued to
// the ALU as a LOAD cycle followed by an EXEC cycle. The EXEC result comes back
// as a one-cycle strobe. A MULT overflow takes a one-cycle error detour that
// clears the accumulator.
//
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
// are both high. cmd_ready does not depend on cmd_valid in the same cycle. A
// result is valid only in the cycle res_valid is high, and res_err qualifies it.
module alu_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cmd_valid,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_operand,
    output logic         cmd_ready,
    input  logic [W-1:0] alu_result,
    input  logic         alu_ovf,
    output logic [2:0]   in_sel,
    output logic [6:0]   out_sel,
    output logic [W-1:0] num2,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic [1:0]   state,
    output logic [7:0]   err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_MULT  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [2:0] SEL_PERSIST = 3'b001;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b100;

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_ERR   = 2'b11
    } state_t;

    typedef enum logic {
        PH_LOAD = 1'b0,
        PH_EXEC = 1'b1
    } phase_t;

    // Maps an opcode to the ALU's one-hot operation select. CLEAR runs as an
    // AND against a freshly cleared accumulator.
    function automatic logic [6:0] op_onehot(input logic [2:0] op);
        logic [6:0] sel;
        case (op)
            3'd0:    sel = 7'b0000001;
            3'd1:    sel = 7'b0000010;
            3'd2:    sel = 7'b0001000;
            3'd3:    sel = 7'b0000100;
            3'd4:    sel = 7'b0010000;
            3'd5:    sel = 7'b0100000;
            3'd6:    sel = 7'b1000000;
            default: sel = 7'b0000001;
        endcase
        return sel;
    endfunction

    // FIFO storage and bookkeeping.
    logic [W+2:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          push, pop;
    logic [2:0]    head_op;
    logic [W-1:0]  head_operand;

    // Sequencer state and registered outputs.
    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    in_sel_q, in_sel_d;
    logic [6:0]    out_sel_q, out_sel_d;
    logic [W-1:0]  num2_q, num2_d;
    logic          res_valid_q, res_valid_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic          res_err_q, res_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          ovf_hit;

    assign push         = cmd_valid && ready_q;
    assign head_op      = mem_q[rd_ptr_q][W+2:W];
    assign head_operand = mem_q[rd_ptr_q][W-1:0];

    // The next count drives a registered ready, so cmd_ready is low in reset
    // and rises on the same edge that frees a slot.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(DEPTH));
    end

    // Command storage is written only on an accepted push and needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_operand};
        end
    end

    // FIFO pointers, occupancy and ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic, then output decoding from the state being entered so
    // that every ALU control is registered and lines up with its own phase.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        op_d        = op_q;
        num2_d      = num2_q;
        pop         = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        ovf_hit     = 1'b0;
        in_sel_d    = SEL_RESET;
        out_sel_d   = '0;

        case (state_q)
            S_OFF: begin
                if (en) state_d = S_READY;
            end
            S_READY: begin
                if (!en) begin
                    state_d = S_OFF;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_RUN;
                    phase_d = PH_LOAD;
                    op_d    = head_op;
                    num2_d  = head_operand;
                end
            end
            S_RUN: begin
                if (phase_q == PH_LOAD) begin
                    phase_d = PH_EXEC;
                end else begin
                    ovf_hit     = alu_ovf && (op_q == OP_MULT);
                    res_valid_d = 1'b1;
                    res_data_d  = alu_result;
                    res_err_d   = ovf_hit;
                    phase_d     = PH_LOAD;
                    if (ovf_hit) begin
                        state_d = S_ERR;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end else if (en && (count_q != '0)) begin
                        pop     = 1'b1;
                        op_d    = head_op;
                        num2_d  = head_operand;
                    end else if (!en) begin
                        state_d = S_OFF;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
            default: begin
                state_d = S_READY;
            end
        endcase

        case (state_d)
            S_READY: in_sel_d = SEL_PERSIST;
            S_RUN: begin
                if (phase_d == PH_LOAD) begin
                    in_sel_d = (op_d == OP_CLEAR) ? SEL_RESET : SEL_LOAD;
                end else begin
                    in_sel_d  = SEL_PERSIST;
                    out_sel_d = op_onehot(op_d);
                end
            end
            default: in_sel_d = SEL_RESET;
        endcase
    end

    // State register and registered outputs. Reset aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OFF;
            phase_q     <= PH_LOAD;
            op_q        <= '0;
            in_sel_q    <= SEL_RESET;
            out_sel_q   <= '0;
            num2_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            op_q        <= op_d;
            in_sel_q    <= in_sel_d;
            out_sel_q   <= out_sel_d;
            num2_q      <= num2_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready = ready_q;
    assign in_sel    = in_sel_q;
    assign out_sel   = out_sel_q;
    assign num2      = num2_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign state     = state_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural accumulator ALU attached.
module tb_alu_sequencer;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_operand = '0;
    logic         cmd_ready;
    logic [W-1:0] alu_result;
    logic         alu_ovf;
    logic [2:0]   in_sel;
    logic [6:0]   out_sel;
    logic [W-1:0] num2;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_err;
    logic [1:0]   state;
    logic [7:0]   err_cnt;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_ready   (cmd_ready),
        .alu_result  (alu_result),
        .alu_ovf     (alu_ovf),
        .in_sel      (in_sel),
        .out_sel     (out_sel),
        .num2        (num2),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_err     (res_err),
        .state       (state),
        .err_cnt     (err_cnt)
    );

    // ---------------- ALU plant model ----------------
    logic [W-1:0] acc = '0;
    logic [15:0]  prod;

    always_comb begin
        prod       = {8'd0, acc} * {8'd0, num2};
        alu_result = acc;
        alu_ovf    = 1'b0;
        if (out_sel[0])      alu_result = acc & num2;
        else if (out_sel[1]) alu_result = acc | num2;
        else if (out_sel[2]) alu_result = ~acc;
        else if (out_sel[3]) alu_result = acc ^ num2;
        else if (out_sel[4]) alu_result = acc + num2;
        else if (out_sel[5]) alu_result = acc - num2;
        else if (out_sel[6]) begin
            alu_result = prod[7:0];
            alu_ovf    = (prod[15:8] != 8'd0);
        end
    end

    always @(posedge clk) begin
        if (in_sel[2])       acc <= '0;
        else if (|out_sel)   acc <= alu_result;
    end

    // ---------------- monitor ----------------
    int           cyc = 0;
    logic [W-1:0] obs_d[$];
    logic         obs_e[$];
    int           obs_c[$];
    logic [1:0]   st_log[$];
    logic [1:0]   prev_st = 2'b00;
    logic         prev_rv = 1'b0;
    logic [2:0]   err_in_sel = 3'b000;
    int           err_cycles = 0;
    int           dbl = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (res_valid) begin
            obs_d.push_back(res_data);
            obs_e.push_back(res_err);
            obs_c.push_back(cyc);
            if (prev_rv) dbl = dbl + 1;
        end
        prev_rv = res_valid;
        if (state != prev_st) begin
            st_log.push_back(state);
            if (state == 2'b11) err_in_sel = in_sel;
        end
        if (state == 2'b11) err_cycles = err_cycles + 1;
        prev_st = state;
    end

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [W-1:0] opnd);
        bit done;
        done        = 1'b0;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = opnd;
        for (int i = 0; i < 30 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) check("push_timeout", 32'(done), 32'd1);
    endtask

    task automatic clear_logs();
        obs_d.delete();
        obs_e.delete();
        obs_c.delete();
        st_log.delete();
        err_cycles = 0;
    endtask

    // Waits for n strobes, then compares them to exp_q; back-to-back results
    // must be exactly two cycles apart. Returns the first strobe's cycle stamp.
    task automatic check_results(input string tag, input int n, output int first_c);
        logic [W:0]   e;
        logic [W-1:0] d;
        logic         r;
        int           c, pc;
        first_c = -1;
        pc      = 0;
        for (int i = 0; i < 200 && obs_d.size() < n; i++) tick();
        check($sformatf("%s_count", tag), 32'(obs_d.size() >= n), 32'd1);
        for (int i = 0; i < n && obs_d.size() > 0; i++) begin
            e = exp_q.pop_front();
            d = obs_d.pop_front();
            r = obs_e.pop_front();
            c = obs_c.pop_front();
            check($sformatf("%s_data%0d", tag, i), 32'(d), 32'(e[W-1:0]));
            check($sformatf("%s_err%0d", tag, i), 32'(r), 32'(e[W]));
            if (i == 0) first_c = c;
            else check($sformatf("%s_gap%0d", tag, i), 32'(c - pc), 32'd2);
            pc = c;
        end
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0, fc;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_in_sel", 32'(in_sel), 32'd4);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_num2", 32'(num2), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        clear_logs();

        // T1: CLEAR, ADD 5, ADD 250 -> 0, 5, 255
        en = 1'b1;
        push(3'd7, 8'd0);
        push(3'd4, 8'd5);
        push(3'd4, 8'd250);
        exp_q.push_back({1'b0, 8'd0});
        exp_q.push_back({1'b0, 8'd5});
        exp_q.push_back({1'b0, 8'd255});
        check_results("t1", 3, fc);
        repeat (3) tick();
        check("t1_st_len", 32'(st_log.size()), 32'd3);
        if (st_log.size() == 3) begin
            check("t1_st0", 32'(st_log[0]), 32'd1);
            check("t1_st1", 32'(st_log[1]), 32'd2);
            check("t1_st2", 32'(st_log[2]), 32'd1);
        end
        check("t1_idle_in_sel", 32'(in_sel), 32'd1);

        // T2: CLEAR, ADD 200, ADD 100 -> 0, 200, 44 (wrap)
        clear_logs();
        push(3'd7, 8'd0);
        push(3'd4, 8'd200);
        push(3'd4, 8'd100);
        exp_q.push_back({1'b0, 8'd0});
        exp_q.push_back({1'b0, 8'd200});
        exp_q.push_back({1'b0, 8'd44});
        check_results("t2", 3, fc);
        repeat (3) tick();

        // T3: CLEAR, ADD 20, MULT 20 -> 400 overflows, low byte 144 flagged
        clear_logs();
        push(3'd7, 8'd0);
        push(3'd4, 8'd20);
        push(3'd6, 8'd20);
        exp_q.push_back({1'b0, 8'd0});
        exp_q.push_back({1'b0, 8'd20});
        exp_q.push_back({1'b1, 8'd144});
        check_results("t3", 3, fc);
        repeat (3) tick();
        check("t3_st_len", 32'(st_log.size()), 32'd3);
        if (st_log.size() == 3) begin
            check("t3_st0", 32'(st_log[0]), 32'd2);
            check("t3_st1", 32'(st_log[1]), 32'd3);
            check("t3_st2", 32'(st_log[2]), 32'd1);
        end
        check("t3_err_cycles", 32'(err_cycles), 32'd1);
        check("t3_err_in_sel", 32'(err_in_sel), 32'd4);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);

        // T4: fill FIFO while off, then drain: 1, 3, 6, 5
        en = 1'b0;
        tick();
        check("t4_off", 32'(state), 32'd0);
        clear_logs();
        push(3'd4, 8'd1);
        push(3'd4, 8'd2);
        push(3'd4, 8'd3);
        push(3'd5, 8'd1);
        check("t4_full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid   = 1'b1;
        cmd_op      = 3'd4;
        cmd_operand = 8'd100;
        repeat (2) tick();
        check("t4_full_hold", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        check("t4_no_res_off", 32'(obs_d.size()), 32'd0);
        en = 1'b1;
        c0 = cyc;
        tick();
        check("t4_ready_pre_pop", 32'(cmd_ready), 32'd0);
        tick();
        check("t4_ready_post_pop", 32'(cmd_ready), 32'd1);
        exp_q.push_back({1'b0, 8'd1});
        exp_q.push_back({1'b0, 8'd3});
        exp_q.push_back({1'b0, 8'd6});
        exp_q.push_back({1'b0, 8'd5});
        check_results("t4", 4, fc);
        check("t4_latency", 32'(fc - c0), 32'd4);
        repeat (4) tick();
        check("t4_no_extra", 32'(obs_d.size()), 32'd0);

        // T5: drop en during LOAD of OR 0x0F; the command still completes
        push(3'd1, 8'h0F);
        push(3'd4, 8'd1);
        en = 1'b0;
        check("t5_load_state", 32'(state), 32'd2);
        check("t5_load_in_sel", 32'(in_sel), 32'd2);
        check("t5_load_num2", 32'(num2), 32'h0F);
        check("t5_load_out_sel", 32'(out_sel), 32'd0);
        tick();
        check("t5_exec_out_sel", 32'(out_sel), 32'b0000010);
        check("t5_exec_in_sel", 32'(in_sel), 32'd1);
        check("t5_exec_num2", 32'(num2), 32'h0F);
        check("t5_exec_no_valid", 32'(res_valid), 32'd0);
        tick();
        check("t5_res_valid", 32'(res_valid), 32'd1);
        check("t5_res_data", 32'(res_data), 32'h0F);
        check("t5_res_err", 32'(res_err), 32'd0);
        check("t5_off_state", 32'(state), 32'd0);
        check("t5_off_in_sel", 32'(in_sel), 32'd4);
        repeat (4) tick();
        check("t5_held_data", 32'(res_data), 32'h0F);
        check("t5_one_result", 32'(obs_d.size()), 32'd1);
        clear_logs();
        en = 1'b1;
        exp_q.push_back({1'b0, 8'd1});
        check_results("t5", 1, fc);
        repeat (3) tick();

        // T6: reset during EXEC aborts the command and empties the FIFO
        push(3'd4, 8'd7);
        push(3'd4, 8'd9);
        tick();
        check("t6_in_exec", 32'(out_sel), 32'b0010000);
        rst = 1'b1;
        #1;
        check("t6_rst_state", 32'(state), 32'd0);
        check("t6_rst_valid", 32'(res_valid), 32'd0);
        check("t6_rst_ready", 32'(cmd_ready), 32'd0);
        check("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("t6_rst_in_sel", 32'(in_sel), 32'd4);
        tick();
        check("t6_rst_no_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        clear_logs();
        repeat (8) tick();
        check("t6_no_result", 32'(obs_d.size()), 32'd0);
        check("t6_ready_state", 32'(state), 32'd1);
        check("t6_cmd_ready", 32'(cmd_ready), 32'd1);

        check("no_double_strobe", 32'(dbl), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
